// File: rtl/tt_um_axi4lite_top_if.sv
// Tiny Tapeout pin bundle for tt_um_axi4lite_top.
// The harness side drives the inputs and the chip side drives the outputs.
interface tt_um_axi4lite_top_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_axi4lite_top.sv
// Tiny Tapeout top: pin-driven AXI4-Lite master wired to an internal AXI4-Lite register-file slave.
// Optional macro AXI4LITE_BUSY_OUT_EN drives the FSM busy flag onto uo_out[1].
module tt_um_axi4lite_top #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tt_um_axi4lite_top_if.slave  pins
);
    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA} state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [0:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    logic                  start_write;
    logic                  start_read;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  write_accept;
    logic                  read_accept;
    logic                  b_done;
    logic                  r_done;
    logic                  done;
    logic                  busy;
    logic                  out_en;
    logic [7:0]            read_data;
    logic [DATA_WIDTH-1:0] regs [2**ADDR_WIDTH];
    logic                  unused_pins;

    // write_addr and read_addr overlap on ui_in[2]
    assign start_write = pins.ui_in[0];
    assign start_read  = pins.ui_in[4];
    assign write_addr  = pins.ui_in[1 +: ADDR_WIDTH];
    assign read_addr   = pins.ui_in[2 +: ADDR_WIDTH];

    assign wstrb  = 1'b1;
    assign bready = 1'b1;
    assign rready = 1'b1;
    assign b_done = bvalid && bready;
    assign r_done = rvalid && rready;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        arvalid      = 1'b0;
        write_accept = 1'b0;
        read_accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start_write) begin
                    next_state   = WRITE;
                    write_accept = 1'b1;
                end else if (start_read) begin
                    next_state  = READ;
                    read_accept = 1'b1;
                end
            end
            WRITE: begin
                awvalid = 1'b1;
                wvalid  = 1'b1;
                if (awready && wready) begin
                    next_state = WRESP;
                end
            end
            WRESP: begin
                if (b_done) begin
                    next_state = IDLE;
                end
            end
            READ: begin
                arvalid = 1'b1;
                if (arready) begin
                    next_state = RDATA;
                end
            end
            RDATA: begin
                if (r_done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            awaddr    <= '0;
            wdata     <= '0;
            araddr    <= '0;
            done      <= 1'b0;
            read_data <= 8'h00;
            out_en    <= 1'b0;
        end else begin
            done <= ((state == WRESP) && b_done) || ((state == RDATA) && r_done);
            if (write_accept) begin
                awaddr <= write_addr;
                wdata  <= pins.uio_in[DATA_WIDTH-1:0];
                out_en <= 1'b0;
            end
            if (read_accept) begin
                araddr <= read_addr;
            end
            if ((state == RDATA) && r_done) begin
                read_data <= 8'(rdata);
                out_en    <= 1'b1;
            end
        end
    end

    // Slave side: AW and W are only taken together, and only while no response is pending
    assign awready = awvalid && wvalid && !bvalid;
    assign wready  = awready;
    assign arready = !rvalid;
    assign bresp   = 2'b00;
    assign rresp   = 2'b00;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2**ADDR_WIDTH; i++) begin
                regs[i] <= '0;
            end
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            if (awvalid && awready) begin
                if (wstrb[0]) begin
                    regs[awaddr] <= wdata;
                end
                bvalid <= 1'b1;
            end else if (b_done) begin
                bvalid <= 1'b0;
            end
            if (arvalid && arready) begin
                rdata  <= regs[araddr];
                rvalid <= 1'b1;
            end else if (r_done) begin
                rvalid <= 1'b0;
            end
        end
    end

`ifdef AXI4LITE_BUSY_OUT_EN
    assign busy = (state != IDLE);
`else
    assign busy = 1'b0;
`endif

    assign pins.uo_out  = {6'b000000, busy, done};
    assign pins.uio_out = read_data;
    assign pins.uio_oe  = {8{out_en}};

    assign unused_pins = &{1'b0, pins.ena, pins.ui_in, pins.uio_in, bresp, rresp};
endmodule

// File: tb/tb_tt_um_axi4lite_top.sv
// Table-driven bench for tt_um_axi4lite_top: directed write/read vectors plus hand-written corner sequences.
// Honours AXI4LITE_BUSY_OUT_EN when checking uo_out[1].
module tb_tt_um_axi4lite_top;
    typedef struct {
        logic       is_write;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] exp_out;
        logic [7:0] exp_oe;
    } vec_t;

`ifdef AXI4LITE_BUSY_OUT_EN
    localparam logic BUSY_ON = 1'b1;
`else
    localparam logic BUSY_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;
    vec_t vecs[14];

    tt_um_axi4lite_top_if bus();

    tt_um_axi4lite_top #(
        .ADDR_WIDTH(2),
        .DATA_WIDTH(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .pins (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic w, input logic [1:0] a, input logic [7:0] d,
                                input logic [7:0] eo, input logic [7:0] eoe);
        vec_t v;
        v.is_write = w;
        v.addr     = a;
        v.data     = d;
        v.exp_out  = eo;
        v.exp_oe   = eoe;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %02h required %02h", name, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic countDone(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.uo_out[0] === 1'b1) n++;
        end
    endtask

    // One start pulse, then the exact done timing and the read-data pins at the completion edge
    task automatic applyStimulus(input vec_t v, input string tag);
        bus.ui_in  = v.is_write ? {5'b00000, v.addr, 1'b1} : {3'b000, 1'b1, v.addr, 2'b00};
        bus.uio_in = v.data;
        tick();
        bus.ui_in  = 8'h00;
        checkOutput({tag, " uo_out@N"}, bus.uo_out, {6'b000000, BUSY_ON, 1'b0});
        tick();
        checkOutput({tag, " uo_out@N+1"}, bus.uo_out, {6'b000000, BUSY_ON, 1'b0});
        tick();
        checkOutput({tag, " uo_out@N+2"}, bus.uo_out, 8'h01);
        checkOutput({tag, " uio_out"}, bus.uio_out, v.exp_out);
        checkOutput({tag, " uio_oe"}, bus.uio_oe, v.exp_oe);
        tick();
        checkOutput({tag, " uo_out@N+3"}, bus.uo_out, 8'h00);
    endtask

    initial begin
        int n;
        int extra;
        checks = 0;
        fails  = 0;

        vecs[0]  = mk(1'b1, 2'd2, 8'h04, 8'h00, 8'h00);
        vecs[1]  = mk(1'b0, 2'd2, 8'h00, 8'h04, 8'hFF);
        vecs[2]  = mk(1'b0, 2'd0, 8'h00, 8'h00, 8'hFF);
        vecs[3]  = mk(1'b0, 2'd3, 8'h00, 8'h00, 8'hFF);
        vecs[4]  = mk(1'b1, 2'd0, 8'h11, 8'h00, 8'h00);
        vecs[5]  = mk(1'b1, 2'd1, 8'h22, 8'h00, 8'h00);
        vecs[6]  = mk(1'b1, 2'd2, 8'h33, 8'h00, 8'h00);
        vecs[7]  = mk(1'b1, 2'd3, 8'h44, 8'h00, 8'h00);
        vecs[8]  = mk(1'b0, 2'd0, 8'h00, 8'h11, 8'hFF);
        vecs[9]  = mk(1'b0, 2'd1, 8'h00, 8'h22, 8'hFF);
        vecs[10] = mk(1'b0, 2'd2, 8'h00, 8'h33, 8'hFF);
        vecs[11] = mk(1'b0, 2'd3, 8'h00, 8'h44, 8'hFF);
        vecs[12] = mk(1'b1, 2'd1, 8'h5A, 8'h44, 8'h00);
        vecs[13] = mk(1'b0, 2'd1, 8'h00, 8'h5A, 8'hFF);

        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        rst_n      = 1'b1;
        tick();
        tick();
        checkOutput("reset uo_out", bus.uo_out, 8'h00);
        checkOutput("reset uio_out", bus.uio_out, 8'h00);
        checkOutput("reset uio_oe", bus.uio_oe, 8'h00);
        rst_n = 1'b0;
        tick();
        checkOutput("idle uo_out", bus.uo_out, 8'h00);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Both starts together: write to addr 1 wins, the read (addr 0) is dropped
        bus.ui_in  = 8'h13;
        bus.uio_in = 8'hA5;
        tick();
        bus.ui_in  = 8'h00;
        countDone(6, n);
        checkCount("simul done pulses", n, 1);
        checkOutput("simul uio_out held", bus.uio_out, 8'h5A);
        checkOutput("simul uio_oe", bus.uio_oe, 8'h00);
        applyStimulus(mk(1'b0, 2'd1, 8'h00, 8'hA5, 8'hFF), "simul readback");

        // A read start that arrives during WRESP must be ignored
        bus.ui_in  = 8'h07;
        bus.uio_in = 8'h77;
        tick();
        bus.ui_in  = 8'h00;
        tick();
        checkOutput("busy wresp uo_out", bus.uo_out, {6'b000000, BUSY_ON, 1'b0});
        bus.ui_in = 8'h1C;
        tick();
        bus.ui_in = 8'h00;
        checkOutput("busy done uo_out", bus.uo_out, 8'h01);
        countDone(6, extra);
        checkCount("busy extra done pulses", extra, 0);
        checkOutput("busy uio_out held", bus.uio_out, 8'hA5);
        checkOutput("busy uio_oe", bus.uio_oe, 8'h00);

        // A held read start re-triggers on the first IDLE cycle: done at N+2 and again at N+5
        bus.ui_in = 8'h1C;
        tick();
        tick();
        tick();
        checkOutput("held done@N+2", bus.uo_out, 8'h01);
        checkOutput("held uio_out", bus.uio_out, 8'h77);
        tick();
        checkOutput("held done@N+3", bus.uo_out, {6'b000000, BUSY_ON, 1'b0});
        tick();
        checkOutput("held done@N+4", bus.uo_out, {6'b000000, BUSY_ON, 1'b0});
        tick();
        bus.ui_in = 8'h00;
        checkOutput("held done@N+5", bus.uo_out, 8'h01);
        countDone(4, n);
        checkCount("held trailing pulses", n, 0);

        // Reset at N+1 of a write aborts it
        bus.ui_in  = 8'h01;
        bus.uio_in = 8'hEE;
        tick();
        bus.ui_in = 8'h00;
        rst_n     = 1'b1;
        tick();
        checkOutput("midreset uo_out", bus.uo_out, 8'h00);
        checkOutput("midreset uio_out", bus.uio_out, 8'h00);
        checkOutput("midreset uio_oe", bus.uio_oe, 8'h00);
        rst_n = 1'b0;
        countDone(4, n);
        checkCount("midreset done pulses", n, 0);
        applyStimulus(mk(1'b0, 2'd0, 8'h00, 8'h00, 8'hFF), "midreset read0");
        applyStimulus(mk(1'b0, 2'd3, 8'h00, 8'h00, 8'hFF), "midreset read3");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
